// File: rtl/servo_pwm_out.sv
// Four-channel servo pulse generator with frame-synchronous double buffering.
// Optional failsafe watchdog enabled by defining SERVO_FAILSAFE_EN.
module servo_pwm_out #(
    parameter int TICK_DIV    = 48,
    parameter int FRAME_US    = 20000,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int WDOG_FRAMES = 25
) (
    input  logic        SYS_CLK,
    input  logic        RST_N,
    input  logic [63:0] SERVO_POS,
    input  logic [3:0]  SERVO_EN,
    input  logic        CMD_STROBE,
    output logic [3:0]  SERVO_OUT,
    output logic        FRAME_SYNC,
    output logic [3:0]  CLAMPED,
    output logic        FAULT
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef SERVO_FAILSAFE_EN
        , S_FAIL = 2'd2
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_presc;
    logic [FW-1:0]     r_fcnt;
    logic [FW-1:0]     w_fcnt_nxt;
    logic              w_tick;
    logic              w_load;
    logic [15:0]       r_w [4];
    logic [15:0]       w_w_nxt [4];
    logic [15:0]       w_cl [4];
    logic [3:0]        w_clhit;
    logic [3:0]        r_en;
    logic [3:0]        w_en_nxt;
    logic [3:0]        r_out;
    logic [3:0]        w_out_nxt;
    logic              r_sync;
    logic [3:0]        r_clamped;

    function automatic logic [15:0] f_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v < 16'(MIN_US))
            r = 16'(MIN_US);
        else if (v > 16'(MAX_US))
            r = 16'(MAX_US);
        return r;
    endfunction

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));
    assign w_load = w_tick && (r_fcnt == FW'(FRAME_US - 1));

    always_comb begin
        w_fcnt_nxt = r_fcnt;
        if (w_load)
            w_fcnt_nxt = '0;
        else if (w_tick)
            w_fcnt_nxt = r_fcnt + 1'b1;
    end

    always_comb begin
        w_en_nxt = w_load ? SERVO_EN : r_en;
        for (int i = 0; i < 4; i++) begin
            w_cl[i]    = f_clamp(SERVO_POS[16*i +: 16]);
            w_clhit[i] = (w_cl[i] != SERVO_POS[16*i +: 16]);
            w_w_nxt[i] = w_load ? w_cl[i] : r_w[i];
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc   <= '0;
            r_fcnt    <= FW'(FRAME_US - 1);
            r_en      <= '0;
            r_clamped <= '0;
            for (int i = 0; i < 4; i++)
                r_w[i] <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_fcnt  <= w_fcnt_nxt;
            r_en    <= w_en_nxt;
            for (int i = 0; i < 4; i++)
                r_w[i] <= w_w_nxt[i];
            if (w_load)
                r_clamped <= w_clhit;
        end
    end

`ifdef SERVO_FAILSAFE_EN
    localparam int WW = $clog2(WDOG_FRAMES + 1);

    logic [WW-1:0] r_wd;
    logic          r_arm;
    logic          w_wd_trip;

    // Strobe on the load edge counts toward the ending frame.
    assign w_wd_trip = !CMD_STROBE && (r_wd >= WW'(WDOG_FRAMES - 1));

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wd  <= '0;
            r_arm <= 1'b0;
        end else begin
            if (CMD_STROBE)
                r_wd <= '0;
            else if (w_load) begin
                if (r_state == S_FAIL && r_arm)
                    r_wd <= '0;
                else if (r_wd != WW'(WDOG_FRAMES))
                    r_wd <= r_wd + 1'b1;
            end
            if (r_state == S_FAIL && w_state_nxt == S_RUN)
                r_arm <= 1'b0;
            else if (r_state == S_FAIL && CMD_STROBE)
                r_arm <= 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused = CMD_STROBE ^ (WDOG_FRAMES != 0);
`endif

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:
                if (w_load)
                    w_state_nxt = S_RUN;
`ifdef SERVO_FAILSAFE_EN
            S_RUN:
                if (w_load && w_wd_trip)
                    w_state_nxt = S_FAIL;
            S_FAIL:
                if (w_load && (r_arm || CMD_STROBE))
                    w_state_nxt = S_RUN;
`else
            S_RUN:
                w_state_nxt = S_RUN;
`endif
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from next-cycle values so edges land on the load edge.
    always_comb begin
        for (int i = 0; i < 4; i++)
            w_out_nxt[i] = (w_state_nxt == S_RUN) && w_en_nxt[i] &&
                           (32'(w_fcnt_nxt) < 32'(w_w_nxt[i]));
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out  <= '0;
            r_sync <= 1'b0;
        end else begin
            r_out  <= w_out_nxt;
            r_sync <= w_load;
        end
    end

    assign SERVO_OUT  = r_out;
    assign FRAME_SYNC = r_sync;
    assign CLAMPED    = r_clamped;

`ifdef SERVO_FAILSAFE_EN
    assign FAULT = (r_state == S_FAIL);
`else
    assign FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm_out.sv
// Scoreboard bench for servo_pwm_out: expected pulse lengths are queued per
// channel and a negedge monitor measures and compares every pulse.
module tb_servo_pwm_out;

    logic        SYS_CLK;
    logic        RST_N;
    logic [63:0] SERVO_POS;
    logic [3:0]  SERVO_EN;
    logic        CMD_STROBE;
    logic [3:0]  SERVO_OUT;
    logic        FRAME_SYNC;
    logic [3:0]  CLAMPED;
    logic        FAULT;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [4][$];
    int cnt [4];
    bit keep_alive = 1'b1;
    bit strobe_req = 1'b0;
    int n;

    servo_pwm_out #(
        .TICK_DIV(4), .FRAME_US(100), .MIN_US(5), .MAX_US(25), .WDOG_FRAMES(3)
    ) dut (
        .SYS_CLK(SYS_CLK), .RST_N(RST_N), .SERVO_POS(SERVO_POS),
        .SERVO_EN(SERVO_EN), .CMD_STROBE(CMD_STROBE), .SERVO_OUT(SERVO_OUT),
        .FRAME_SYNC(FRAME_SYNC), .CLAMPED(CLAMPED), .FAULT(FAULT)
    );

    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // One strobe per frame while keep_alive is set, plus on-demand strobes.
    initial begin
        CMD_STROBE = 1'b0;
        forever begin
            @(posedge SYS_CLK);
            #2;
            CMD_STROBE = (keep_alive && FRAME_SYNC === 1'b1) || strobe_req;
        end
    end

    always @(negedge SYS_CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (SERVO_OUT[i] === 1'b1) begin
                cnt[i]++;
            end else if (cnt[i] != 0) begin
                if (exp_q[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pulse_ch%0d: got %0d cycles expected none",
                             i, cnt[i]);
                end else begin
                    chk($sformatf("pulse_ch%0d", i), 64'(cnt[i]),
                        64'(exp_q[i].pop_front()));
                end
                cnt[i] = 0;
            end
        end
    end

    task automatic wait_sync(output int cycles);
        cycles = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge SYS_CLK);
            #1;
            cycles++;
            if (FRAME_SYNC === 1'b1) return;
        end
        chk("sync_timeout", 64'(cycles), 64'd0);
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        if (a > 0) exp_q[0].push_back(a);
        if (b > 0) exp_q[1].push_back(b);
        if (c > 0) exp_q[2].push_back(c);
        if (d > 0) exp_q[3].push_back(d);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        RST_N     = 1'b0;
        SERVO_EN  = 4'b0001;
        SERVO_POS = {16'd10, 16'd10, 16'd10, 16'd10};
        repeat (3) @(posedge SYS_CLK);
        #1;
        chk("rst_out", 64'(SERVO_OUT), 64'h0);
        chk("rst_sync", 64'(FRAME_SYNC), 64'h0);
        chk("rst_clamped", 64'(CLAMPED), 64'h0);
        chk("rst_fault", 64'(FAULT), 64'h0);

        push4(40, 0, 0, 0);
        RST_N = 1'b1;
        wait_sync(n);
        chk("first_sync_latency", 64'(n), 64'd4);
        chk("f1_out", 64'(SERVO_OUT), 64'b0001);
        chk("f1_clamped", 64'(CLAMPED), 64'b0000);

        SERVO_POS = {16'd25, 16'hFFFF, 16'd2, 16'd10};
        SERVO_EN  = 4'b1111;
        push4(40, 20, 100, 100);
        wait_sync(n);
        chk("frame_period", 64'(n), 64'd400);
        chk("f2_clamped", 64'(CLAMPED), 64'b0110);
        chk("f2_out", 64'(SERVO_OUT), 64'b1111);

        push4(80, 20, 100, 100);
        repeat (20) @(posedge SYS_CLK);
        #1;
        SERVO_POS[15:0] = 16'd20;
        chk("midframe_out", 64'(SERVO_OUT[0]), 64'd1);
        wait_sync(n);
        chk("frame_period2", 64'(n), 64'd380);
        chk("f3_out", 64'(SERVO_OUT), 64'b1111);

        SERVO_EN = 4'b0001;
        push4(12, 0, 0, 0);
        wait_sync(n);
        chk("f4_out", 64'(SERVO_OUT), 64'b0001);
        chk("f4_clamped", 64'(CLAMPED), 64'b0110);
        repeat (12) @(posedge SYS_CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("async_rst_out", 64'(SERVO_OUT), 64'h0);
        chk("async_rst_clamped", 64'(CLAMPED), 64'h0);
        repeat (3) @(posedge SYS_CLK);
        #1;
        push4(80, 0, 0, 0);
        RST_N = 1'b1;
        wait_sync(n);
        chk("resync_latency", 64'(n), 64'd4);
        chk("r1_out", 64'(SERVO_OUT), 64'b0001);
        keep_alive = 1'b0;

`ifdef SERVO_FAILSAFE_EN
        push4(80, 0, 0, 0);
        wait_sync(n);
        chk("wd_r2_fault", 64'(FAULT), 64'd0);
        wait_sync(n);
        chk("wd_r3_fault", 64'(FAULT), 64'd1);
        chk("wd_r3_out", 64'(SERVO_OUT), 64'h0);
        strobe_req = 1'b1;
        @(posedge SYS_CLK);
        #1;
        strobe_req = 1'b0;
        chk("fail_hold_fault", 64'(FAULT), 64'd1);
        push4(80, 0, 0, 0);
        wait_sync(n);
        chk("recover_fault", 64'(FAULT), 64'd0);
        chk("recover_out", 64'(SERVO_OUT), 64'b0001);
`else
        for (int f = 0; f < 10; f++) begin
            push4(80, 0, 0, 0);
            wait_sync(n);
            chk($sformatf("nowd_fault_%0d", f), 64'(FAULT), 64'd0);
            chk($sformatf("nowd_out_%0d", f), 64'(SERVO_OUT), 64'b0001);
        end
`endif

        repeat (100) @(posedge SYS_CLK);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("queue_empty_ch%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_out.md
# servo_pwm_out

Four-channel hobby-servo pulse generator that consumes servo position words from the SPI command register space and drives the servo header pins. Sits directly downstream of the SPI slave: the top level slices the four 16-bit servo words and enable bits out of the command register and wires them here. Pulse widths are double-buffered and take effect only at frame boundaries, so SPI writes landing mid-frame never produce a glitched pulse.

## Interface
- TICK_DIV, 48: SYS_CLK cycles per microsecond tick (48 MHz system clock).
- FRAME_US, 20000: frame period in ticks (50 Hz).
- MIN_US, 500: minimum pulse width in ticks; smaller commands clamp up.
- MAX_US, 2500: maximum pulse width in ticks; larger commands clamp down.
- WDOG_FRAMES, 25: frames without a command strobe before failsafe (only with SERVO_FAILSAFE_EN).
- SYS_CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- SERVO_POS  in  64  commanded widths in ticks, unsigned; ch0 = [15:0], ch3 = [63:48].
- SERVO_EN  in  4  per-channel enable; bit i gates channel i.
- CMD_STROBE  in  1  one-cycle pulse when the SPI block completes a command write.
- SERVO_OUT  out  4  servo pulse outputs, registered.
- FRAME_SYNC  out  1  one-cycle pulse in the first cycle of each frame.
- CLAMPED  out  4  channel i's latched width was clamped in the current frame.
- FAULT  out  1  failsafe active.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps; `tick` is true when prescaler == TICK_DIV-1.
- Frame counter `fcnt` (ceil(log2 FRAME_US) bits) advances on `tick`, wrapping FRAME_US-1 -> 0. Load edge = `tick` with fcnt == FRAME_US-1.
- At a load edge, each channel captures `en_sh[i]` <= SERVO_EN[i] and `w_sh[i]` <= clamp(SERVO_POS[i]) into shadow registers. CLAMPED[i] <= 1 when clamping changed the value, else 0. Between load edges, input changes have no effect.
- Clamp: value < MIN_US -> MIN_US; value > MAX_US -> MAX_US. The comparison uses the full 16 bits; 0x0000 -> MIN_US, 0xFFFF -> MAX_US.
- SERVO_OUT[i] is high exactly while en_sh[i] && fcnt < w_sh[i] and state == RUN: that is w_sh[i]*TICK_DIV cycles per frame. Disabled channels stay low for the whole frame.
- FSM states:
  - IDLE (reset): outputs low. Go to RUN at the first load edge.
  - RUN: normal pulsing.
  - FAILSAFE: SERVO_OUT forced low, FAULT = 1. Exists only with SERVO_FAILSAFE_EN.
- Reset values: prescaler 0, fcnt FRAME_US-1, shadows 0/disabled, SERVO_OUT 0, FRAME_SYNC 0, CLAMPED 0, FAULT 0, state IDLE.
- Reset asserted mid-pulse: all outputs drop low asynchronously. After release, timing restarts from the reset values.

## Timing
- First load edge is TICK_DIV cycles after RST_N deasserts: the prescaler reaches TICK_DIV-1 on the TICK_DIV-th clock.
- FRAME_SYNC and the rising edges of enabled SERVO_OUT bits are registered at the load edge and appear in the same cycle. FRAME_SYNC is high for exactly 1 cycle every FRAME_US*TICK_DIV cycles.
- Falling edge of SERVO_OUT[i] is registered at the edge where fcnt becomes w_sh[i]; no further latency.
- SERVO_POS/SERVO_EN sampled in the load-edge cycle take effect in that frame. A value changed in the same cycle as the load edge is taken.
- CMD_STROBE coincident with a load edge counts toward the frame that is ending.

## Configuration
- SERVO_FAILSAFE_EN defined:
  - A frame counter `wd` resets to 0 on any CMD_STROBE and increments at each load edge without a strobe since the previous load edge.
  - When `wd` reaches WDOG_FRAMES, RUN -> FAILSAFE at that load edge.
  - Any CMD_STROBE while in FAILSAFE arms a return: FAILSAFE -> RUN at the next load edge, FAULT clears at that edge, and `wd` resets to 0.
- SERVO_FAILSAFE_EN undefined: CMD_STROBE ignored, FAULT tied 0, FAILSAFE state and `wd` not built.

## Test plan
All scenarios use TICK_DIV=4, FRAME_US=100, MIN_US=5, MAX_US=25, WDOG_FRAMES=3.
- Reset release, SERVO_EN=4'b0001, ch0=10 -> FRAME_SYNC at cycle 4; SERVO_OUT[0] high for 40 cycles; FRAME_SYNC repeats every 400 cycles; other outputs stay 0.
- ch1=2, ch2=0xFFFF, ch3=25, all enabled -> pulse lengths 20/100/100 cycles for ch1/ch2/ch3; CLAMPED=4'b0110.
- Change ch0 from 10 to 20 at fcnt=5 of a frame -> that frame's pulse stays 40 cycles; the next frame's pulse is 80 cycles; no pulse has any other length.
- Assert RST_N low at fcnt=3 with ch0 high -> SERVO_OUT drops to 0 without a clock edge; after release, FRAME_SYNC again arrives 4 cycles later.
- SERVO_FAILSAFE_EN, ch0=10 enabled, no CMD_STROBE -> FAULT=1 and SERVO_OUT=0 from the 3rd load edge after the last strobe; one CMD_STROBE -> pulses resume and FAULT=0 at the next load edge.
- SERVO_FAILSAFE_EN undefined, no strobes for 10 frames -> FAULT stays 0 and pulses continue.
